// File: rtl/mem_pkg.sv
// Shared definitions for the M-stage memory access unit.
// Contents: access op encodings, unit FSM states, byte-enable constants,
// and helpers deriving byte enables, store/load kind and alignment of an access.
package mem_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  function automatic logic is_store(input op_e op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic [3:0] byteen_of(input op_e op, input logic [1:0] addr_lo);
    case (op)
      OP_SW:   return BE_WORD;
      OP_SH:   return addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
      OP_SB:   return BE_BYTE0 << addr_lo;
      default: return BE_NONE;
    endcase
  endfunction

  function automatic logic misaligned(input op_e op, input logic [1:0] addr_lo);
    case (op)
      OP_LW, OP_SW:        return addr_lo != 2'b00;
      OP_LH, OP_LHU, OP_SH: return addr_lo[0];
      default:             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Word-organised data memory port between the access unit and memory.
// master (access unit): drives mem_req/we/addr/byteen/wdata/wpc,
//                       receives mem_gnt/rvalid/rdata.
// slave  (memory):      the reverse.
interface mem_access_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_wdata;
  logic [31:0] mem_wpc;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_byteen, mem_wdata, mem_wpc,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_byteen, mem_wdata, mem_wpc,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// load_extend: picks the addressed byte/half out of a read word and
// sign- or zero-extends it according to the load op.
// Ports: word (read word), addr_lo (address bits [1:0]), op (load op),
//        result (extended load data; LW and non-load ops pass the word).
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  op_e         op,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{addr_lo, 3'b000} +: 8];
    half_sel = word[{addr_lo[1], 4'b0000} +: 16];
    case (op)
      OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  result = {24'h0, byte_sel};
      OP_LH:   result = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  result = {16'h0, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: M-stage load/store initiator. Accepts one access per
// req_valid/req_ready handshake, issues it on the memory port, waits for
// grant (and read data for loads), then pulses resp_valid with extended
// load data. Stalls the pipeline while busy; aborts with bus_err after
// MAX_WAIT cycles in REQ+WAIT.
// Ports: clk, reset (async active-low); req_valid/req_ready/req_op/req_addr/
//        req_wdata/req_pc (pipeline request); mem (memory port, master side);
//        resp_valid/resp_rdata/bus_err (completion); stall.
// Build option: MEM_ALIGN_CHECK_EN - misaligned LW/SW/LH/LHU/SH complete
//        with bus_err without issuing a memory request.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_op,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  input  logic [31:0]        req_pc,
  mem_access_unit_if.master  mem,
  output logic               resp_valid,
  output logic [31:0]        resp_rdata,
  output logic               bus_err,
  output logic               stall
);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  op_e         op_q;
  logic [31:0] addr_q, wdata_q, pc_q;
  logic [3:0]  be_q;
  logic        we_q;
  logic        accept;
  logic        complete;
  logic [31:0] ext_data;
  op_e         op_in;

  assign op_in = op_e'(req_op);

  load_extend u_load_extend (
    .word    (mem.mem_rdata),
    .addr_lo (addr_q[1:0]),
    .op      (op_q),
    .result  (ext_data)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    accept   = 1'b0;
    complete = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          err_d   = 1'b0;
          rdata_d = '0;
          cnt_d   = '0;
`ifdef MEM_ALIGN_CHECK_EN
          if (misaligned(op_in, req_addr[1:0])) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = ST_REQ;
          end
`else
          state_d = ST_REQ;
`endif
        end
      end
      ST_REQ, ST_WAIT: begin
        // Completion wins over timeout when both land in the same cycle.
        if (state_q == ST_REQ) begin
          complete = mem.mem_gnt && (we_q || mem.mem_rvalid);
        end else begin
          complete = mem.mem_rvalid;
        end
        if (complete) begin
          state_d = ST_DONE;
          rdata_d = we_q ? '0 : ext_data;
        end else if (cnt_q == 8'(MAX_WAIT - 1)) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (state_q == ST_REQ && mem.mem_gnt) begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        err_d   = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      op_q    <= OP_LW;
      addr_q  <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (accept) begin
        op_q    <= op_in;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        pc_q    <= req_pc;
        be_q    <= byteen_of(op_in, req_addr[1:0]);
        we_q    <= is_store(op_in);
      end
    end
  end

  assign mem.mem_req    = (state_q == ST_REQ);
  assign mem.mem_we     = we_q;
  assign mem.mem_addr   = addr_q;
  assign mem.mem_byteen = be_q;
  assign mem.mem_wdata  = wdata_q;
  assign mem.mem_wpc    = pc_q;

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_DONE);
  assign resp_rdata = rdata_q;
  assign bus_err    = err_q;
  assign stall      = (req_valid && !req_ready) ||
                      (state_q == ST_REQ) || (state_q == ST_WAIT);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit. Inputs are driven and
// outputs sampled on the falling clock edge; the memory side is played by
// the bench through the interface slave signals.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        bus_err;
  logic        stall;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_unit_if bus ();

  mem_access_unit #(.MAX_WAIT(255)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_pc     (req_pc),
    .mem        (bus),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .bus_err    (bus_err),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic issue(input op_e op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] pc);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    req_pc    = pc;
    #1;
    check({tag_of(op), "_ready"}, {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  function automatic string tag_of(input op_e op);
    return op.name();
  endfunction

  // gnt_dly: extra REQ cycles before grant; rv_dly: cycles after grant
  // until read data (0 = same cycle as grant).
  task automatic access(input string tag, input op_e op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rword,
                        input int unsigned gnt_dly, input int unsigned rv_dly,
                        input logic [3:0] exp_be, input logic [31:0] exp_rdata);
    logic is_ld;
    is_ld = !(op == OP_SW || op == OP_SH || op == OP_SB);
    issue(op, addr, wdata, 32'h0000_4000 + addr);
    check({tag, "_req"},    {31'b0, bus.mem_req}, 32'd1);
    check({tag, "_we"},     {31'b0, bus.mem_we}, {31'b0, !is_ld});
    check({tag, "_addr"},   bus.mem_addr, addr);
    check({tag, "_byteen"}, {28'b0, bus.mem_byteen}, {28'b0, exp_be});
    check({tag, "_wpc"},    bus.mem_wpc, 32'h0000_4000 + addr);
    if (!is_ld) check({tag, "_wdata"}, bus.mem_wdata, wdata);
    check({tag, "_stall"},  {31'b0, stall}, 32'd1);
    repeat (gnt_dly) @(negedge clk);
    check({tag, "_req_held"}, {31'b0, bus.mem_req}, 32'd1);
    bus.mem_gnt = 1'b1;
    if (is_ld && rv_dly == 0) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = rword;
    end
    @(negedge clk);
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    if (is_ld && rv_dly > 0) begin
      check({tag, "_wait_req"}, {31'b0, bus.mem_req}, 32'd0);
      repeat (rv_dly - 1) @(negedge clk);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = rword;
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 32'h0;
    end
    check({tag, "_resp"},  {31'b0, resp_valid}, 32'd1);
    check({tag, "_err"},   {31'b0, bus_err}, 32'd0);
    check({tag, "_rdata"}, resp_rdata, exp_rdata);
    check({tag, "_done_req"}, {31'b0, bus.mem_req}, 32'd0);
    @(negedge clk);
    check({tag, "_resp_pulse"}, {31'b0, resp_valid}, 32'd0);
    check({tag, "_idle"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset          = 1'b0;
    req_valid      = 1'b0;
    req_op         = '0;
    req_addr       = '0;
    req_wdata      = '0;
    req_pc         = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    repeat (3) @(negedge clk);
    check("rst_req",    {31'b0, bus.mem_req}, 32'd0);
    check("rst_we",     {31'b0, bus.mem_we}, 32'd0);
    check("rst_addr",   bus.mem_addr, 32'd0);
    check("rst_byteen", {28'b0, bus.mem_byteen}, 32'd0);
    check("rst_wdata",  bus.mem_wdata, 32'd0);
    check("rst_wpc",    bus.mem_wpc, 32'd0);
    check("rst_resp",   {31'b0, resp_valid}, 32'd0);
    check("rst_rdata",  resp_rdata, 32'd0);
    check("rst_err",    {31'b0, bus_err}, 32'd0);
    check("rst_ready",  {31'b0, req_ready}, 32'd1);
    check("rst_stall",  {31'b0, stall}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    //      tag         op      addr          wdata          rword          g  r  be       rdata
    access("sb13",   OP_SB,  32'h13, 32'h0000_00AB, 32'h0,          2, 0, 4'b1000, 32'h0);
    access("sh02",   OP_SH,  32'h02, 32'h0000_1234, 32'h0,          0, 0, 4'b1100, 32'h0);
    access("sw10",   OP_SW,  32'h10, 32'hDEAD_BEEF, 32'h0,          3, 0, 4'b1111, 32'h0);
    access("sh00",   OP_SH,  32'h00, 32'h0000_5678, 32'h0,          1, 0, 4'b0011, 32'h0);
    access("sb00",   OP_SB,  32'h00, 32'h0000_0011, 32'h0,          0, 0, 4'b0001, 32'h0);
    access("lb01",   OP_LB,  32'h01, 32'h0,         32'h0000_8000,  1, 2, 4'b0000, 32'hFFFF_FF80);
    access("lbu01",  OP_LBU, 32'h01, 32'h0,         32'h0000_8000,  0, 1, 4'b0000, 32'h0000_0080);
    access("lh02",   OP_LH,  32'h02, 32'h0,         32'h8001_0000,  0, 0, 4'b0000, 32'hFFFF_8001);
    access("lhu02",  OP_LHU, 32'h02, 32'h0,         32'h8001_0000,  1, 0, 4'b0000, 32'h0000_8001);
    access("lw10",   OP_LW,  32'h10, 32'h0,         32'h1234_5678,  0, 1, 4'b0000, 32'h1234_5678);
    access("lb03",   OP_LB,  32'h03, 32'h0,         32'h7F00_0000,  0, 0, 4'b0000, 32'h0000_007F);

    // Timeout: no grant at all.
    issue(OP_SW, 32'h20, 32'hCAFE_F00D, 32'h0000_0020);
    n = 0;
    while (bus.mem_req && n < 300) begin
      n++;
      @(negedge clk);
    end
    check("to_req_cycles", n, 32'd255);
    check("to_resp", {31'b0, resp_valid}, 32'd1);
    check("to_err",  {31'b0, bus_err}, 32'd1);
    check("to_req_low", {31'b0, bus.mem_req}, 32'd0);
    check("to_rdata", resp_rdata, 32'd0);
    bus.mem_gnt    = 1'b1;
    bus.mem_rvalid = 1'b1;
    @(negedge clk);
    check("late_idle", {31'b0, req_ready}, 32'd1);
    check("late_resp", {31'b0, resp_valid}, 32'd0);
    check("late_err",  {31'b0, bus_err}, 32'd0);
    @(negedge clk);
    check("late_req",   {31'b0, bus.mem_req}, 32'd0);
    check("late_resp2", {31'b0, resp_valid}, 32'd0);
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    @(negedge clk);

    // Reset while requesting: mem_req drops without a clock edge.
    issue(OP_SW, 32'h24, 32'h1, 32'h0);
    check("rreq_req", {31'b0, bus.mem_req}, 32'd1);
    reset = 1'b0;
    #1;
    check("rreq_async", {31'b0, bus.mem_req}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Reset while waiting for load data: no response afterwards.
    issue(OP_LW, 32'h30, 32'h0, 32'h0);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    check("rwait_busy", {31'b0, stall}, 32'd1);
    reset = 1'b0;
    #1;
    check("rwait_req",   {31'b0, bus.mem_req}, 32'd0);
    check("rwait_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hFFFF_FFFF;
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) n++;
    end
    bus.mem_rvalid = 1'b0;
    check("rwait_noresp", n, 32'd0);
    check("rwait_idle", {31'b0, req_ready}, 32'd1);

`ifdef MEM_ALIGN_CHECK_EN
    issue(OP_LW, 32'h02, 32'h0, 32'h0);
    check("mis_resp", {31'b0, resp_valid}, 32'd1);
    check("mis_err",  {31'b0, bus_err}, 32'd1);
    check("mis_req",  {31'b0, bus.mem_req}, 32'd0);
    check("mis_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    check("mis_idle", {31'b0, req_ready}, 32'd1);
    check("mis_req2", {31'b0, bus.mem_req}, 32'd0);
`else
    access("lw02", OP_LW, 32'h02, 32'h0, 32'hA5A5_0F0F, 0, 0, 4'b0000, 32'hA5A5_0F0F);
    access("sw03", OP_SW, 32'h03, 32'h0102_0304, 32'h0, 0, 0, 4'b1111, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
